// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks all 2^N_IN input vectors (binary or Gray order),
// holds each for HOLD cycles and counts vectors where dut_out differs from ref_out.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | sweeping vectors, sampling at the end of each hold window
// DONE  | sweep finished, results held until next start or reset
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int HOLD  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gray_en,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] ref_out,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic [N_IN:0]    err_count,
    output logic             err_flag,
    output logic [N_IN-1:0]  first_err_vec
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN:0] LAST_IDX  = {1'b0, {N_IN{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] first_q, first_d;
    logic            gray_q, gray_d;
    logic            sample_w;

    function automatic logic [N_IN-1:0] enc(input logic [N_IN:0] i, input logic g);
        logic [N_IN:0] v;
        v = g ? (i ^ (i >> 1)) : i;
        return v[N_IN-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        stim_d   = stim_q;
        err_d    = err_q;
        first_d  = first_q;
        gray_d   = gray_q;
        sample_w = (state_q == RUN) && (hold_q == HOLD_LAST);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    hold_d  = '0;
                    stim_d  = enc('0, gray_en);
                    err_d   = '0;
                    first_d = '0;
                    gray_d  = gray_en;
                end
            end
            RUN: begin
                if (sample_w) begin
                    if (dut_out != ref_out) begin
                        err_d = err_q + (N_IN+1)'(1);
                        if (err_q == '0) first_d = stim_q;
                    end
                    if (idx_q != LAST_IDX) begin
                        idx_d  = idx_q + (N_IN+1)'(1);
                        stim_d = enc(idx_q + (N_IN+1)'(1), gray_q);
                        hold_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            stim_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            gray_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            first_q <= first_d;
            gray_q  <= gray_d;
        end
    end

    assign stim          = stim_q;
    assign sample        = sample_w;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign err_count     = err_q;
    assign err_flag      = (err_q != '0);
    assign first_err_vec = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default instance (N_IN=4, HOLD=20)
// and a small instance (N_IN=3, HOLD=1) with every vector mismatching.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n, start, gray_en, inj;
    logic start1;
    always #5 clk = ~clk;

    logic [3:0] stim0;
    logic [1:0] dut_out0, ref_out0;
    logic       sample0, busy0, done0, err_flag0;
    logic [4:0] err_count0;
    logic [3:0] first0;

    logic [2:0] stim1;
    logic [1:0] dut_out1, ref_out1;
    logic       sample1, busy1, done1, err_flag1;
    logic [3:0] err_count1;
    logic [2:0] first1;

    int checks = 0;
    int errors = 0;

    assign ref_out0 = stim0[1:0] ^ stim0[3:2];
    assign dut_out0 = ref_out0 ^ ((inj && (stim0 == 4'd3 || stim0 == 4'd10)) ? 2'b01 : 2'b00);
    assign ref_out1 = stim1[1:0];
    assign dut_out1 = ~ref_out1;

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .HOLD(20)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .gray_en(gray_en),
        .stim(stim0), .dut_out(dut_out0), .ref_out(ref_out0), .sample(sample0),
        .busy(busy0), .done(done0), .err_count(err_count0), .err_flag(err_flag0),
        .first_err_vec(first0)
    );

    truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .gray_en(1'b0),
        .stim(stim1), .dut_out(dut_out1), .ref_out(ref_out1), .sample(sample1),
        .busy(busy1), .done(done1), .err_count(err_count1), .err_flag(err_flag1),
        .first_err_vec(first1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle0(input string tag);
        check({tag, " stim"}, 32'(stim0), 32'd0);
        check({tag, " busy"}, 32'(busy0), 32'd0);
        check({tag, " done"}, 32'(done0), 32'd0);
        check({tag, " err_count"}, 32'(err_count0), 32'd0);
        check({tag, " err_flag"}, 32'(err_flag0), 32'd0);
        check({tag, " first_err"}, 32'(first0), 32'd0);
        check({tag, " sample"}, 32'(sample0), 32'd0);
    endtask

    // One full sweep on u0; gray_en is flipped after start to show it is latched.
    task automatic sweep0(input logic g);
        int samples;
        int v, e;
        logic [3:0] prev;
        samples = 0;
        prev = '0;
        gray_en = g;
        start = 1'b1;
        tick();
        start = 1'b0;
        gray_en = ~g;
        check("start busy", 32'(busy0), 32'd1);
        check("start done", 32'(done0), 32'd0);
        check("start err_count", 32'(err_count0), 32'd0);
        for (int c = 0; c < 320; c++) begin
            v = c / 20;
            e = g ? (v ^ (v >> 1)) : v;
            if (c % 20 == 0) begin
                check("stim step", 32'(stim0), 32'(e));
                if (g && c > 0) check("gray one bit", 32'($countones(stim0 ^ prev)), 32'd1);
                prev = stim0;
            end
            if (c % 20 == 19) check("sample at hold end", 32'(sample0), 32'd1);
            if (sample0) samples++;
            tick();
        end
        check("sample count", 32'(samples), 32'd16);
        check("end done", 32'(done0), 32'd1);
        check("end busy", 32'(busy0), 32'd0);
        check("end sample", 32'(sample0), 32'd0);
    endtask

    initial begin
        int idle_samples;
        rst_n = 1'b0; start = 1'b0; gray_en = 1'b0; inj = 1'b0; start1 = 1'b0;
        tick();
        tick();
        check_idle0("reset");
        rst_n = 1'b1;

        idle_samples = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (sample0 || busy0 || done0 || stim0 != 4'd0 || err_count0 != 5'd0 || first0 != 4'd0)
                idle_samples++;
        end
        check("idle 100 cycles nonzero cycles", 32'(idle_samples), 32'd0);

        sweep0(1'b0);
        check("clean err_count", 32'(err_count0), 32'd0);
        check("clean err_flag", 32'(err_flag0), 32'd0);
        check("clean first_err", 32'(first0), 32'd0);
        check("binary final stim", 32'(stim0), 32'hF);

        inj = 1'b1;
        sweep0(1'b0);
        inj = 1'b0;
        check("inject err_count", 32'(err_count0), 32'd2);
        check("inject err_flag", 32'(err_flag0), 32'd1);
        check("inject first_err", 32'(first0), 32'h3);

        sweep0(1'b1);
        for (int c = 0; c < 5; c++) tick();
        check("gray DONE stim held", 32'(stim0), 32'h8);
        check("gray DONE still done", 32'(done0), 32'd1);
        check("gray err_count", 32'(err_count0), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 140; c++) tick();
        check("mid stim 7", 32'(stim0), 32'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignored start busy", 32'(busy0), 32'd1);
        check("ignored start stim", 32'(stim0), 32'd7);
        for (int c = 0; c < 19; c++) tick();
        check("ignored start next stim", 32'(stim0), 32'd8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle0("mid reset");
        for (int c = 0; c < 3; c++) tick();
        check("post reset done", 32'(done0), 32'd0);
        check("post reset busy", 32'(busy0), 32'd0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("hold1 sample", 32'(sample1), 32'd1);
            check("hold1 stim", 32'(stim1), 32'(c));
            tick();
        end
        check("hold1 done", 32'(done1), 32'd1);
        check("hold1 sample after", 32'(sample1), 32'd0);
        check("hold1 err_count", 32'(err_count1), 32'd8);
        check("hold1 err_flag", 32'(err_flag1), 32'd1);
        check("hold1 first_err", 32'(first1), 32'd0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("restart err_count", 32'(err_count1), 32'd0);
        check("restart busy", 32'(busy1), 32'd1);
        check("restart done", 32'(done1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Parametrised, clocked exhaustive-stimulus engine for combinational lab blocks.
- Drives all 2^N_IN input combinations onto a device under test, holding each vector for HOLD cycles.
- Compares the DUT outputs against a golden-model output at the end of each hold window, and counts mismatches.
- Replaces hand-written per-vector stimulus lists; supports arbitrary input/output widths, hold time, and binary or Gray-code ordering.

Parameters:
- N_IN, 4, input vector width driven to the DUT (1..16).
- N_OUT, 2, DUT/golden output width compared each vector (>=1).
- HOLD, 20, clock cycles each vector is held (>=1).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
- gray_en  in  1  ordering select, sampled with start: 0 = binary ascending, 1 = reflected Gray code.
- stim  out  N_IN  registered vector driven to the DUT and golden model.
- dut_out  in  N_OUT  DUT response to stim.
- ref_out  in  N_OUT  golden-model response to stim.
- sample  out  1  one-cycle pulse in the cycle the comparison is made.
- busy  out  1  high while sweeping.
- done  out  1  high from sweep completion until the next start or reset.
- err_count  out  N_IN+1  number of mismatching vectors in the current/last sweep.
- err_flag  out  1  err_count != 0.
- first_err_vec  out  N_IN  stim value of the first mismatch; 0 if none.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE, and all outputs 0, including stim, err_count and first_err_vec. Internal index and hold counter are also cleared. Reset mid-sweep aborts immediately; no partial done is produced.
- States: IDLE, RUN, DONE.
- Sweep start:
  - Condition: start=1 while in IDLE or DONE, at edge t.
  - Edge t: go to RUN; busy=1; done=0; err_count=0; first_err_vec=0; index=0; hold_cnt=0; stim=enc(0); gray_en latched.
- Encoding: enc(i)=i when binary; enc(i)=i^(i>>1) when Gray. Index width is N_IN+1 internally so the terminal compare is unambiguous.
- RUN, per-vector timing:
  - hold_cnt increments each cycle from 0 to HOLD-1.
  - In the cycle hold_cnt==HOLD-1, sample=1 and dut_out is compared combinationally against ref_out.
  - On mismatch, err_count increments at that edge; if err_count was 0, first_err_vec is loaded with stim.
- RUN, advancing:
  - At the sampling edge, if index < 2^N_IN-1: index++, stim=enc(index+1), hold_cnt=0.
  - Otherwise go to DONE: busy=0, done=1.
- Latency: first sample at t+HOLD; k-th sample (k from 1) at t+k*HOLD. done and busy=0 are visible from edge t+HOLD*2^N_IN, i.e. seen high in the cycle after the last sample pulse.
- DONE: stim holds the last vector. err_count, err_flag and first_err_vec hold their values. done stays high.
- start while in RUN is ignored; gray_en changes mid-sweep are ignored.
- start in DONE restarts the sweep exactly as from IDLE; counters are cleared in the same edge.
- err_count maximum is 2^N_IN, which fits N_IN+1 bits; no saturation logic is required.
- HOLD=1: sample is high on every RUN cycle and stim changes every cycle.
- err_flag is combinational from err_count.
- dut_out/ref_out are not registered; comparison uses their values in the sample cycle only.

Test Plan:
- Defaults; ref_out tied to dut_out; pulse start -> stim steps 0,1,2..15, each for 20 cycles; 16 sample pulses; done=1 and busy=0 at 320 edges after start; err_count=0, err_flag=0, first_err_vec=0.
- Defaults; dut_out=ref_out^2'b01 only when stim is 4'b0011 or 4'b1010 -> err_count=5'd2, err_flag=1, first_err_vec=4'b0011.
- Defaults; gray_en=1 at start -> stim sequence 0000,0001,0011,0010,0110,...,1000, only one bit changing per step; final stim held at 4'b1000 in DONE.
- Defaults; during RUN at vector 7, assert start -> ignored, sweep unchanged; then drop rst_n for one edge -> next cycle stim=0, busy=0, done=0, err_count=0, sample=0; state IDLE.
- N_IN=3, HOLD=1; ref_out=~dut_out -> sample high 8 consecutive cycles; err_count=4'd8 (all mismatch, no overflow); first_err_vec=3'b000; a new start from DONE clears err_count to 0 in the same edge.
- Defaults; from reset, hold start=0 for 100 cycles -> outputs remain all 0 and sample never pulses.
